rc4_phase_sequencer: RTL and testbench

Top-level controller for the RC4 datapath. It runs the three engines in order on one shared S-RAM (256x8): init (S[i]=i), then shuffle (KSA), then decryptor (PRGA/XOR into A-RAM). It owns the S-RAM port mux, the start/finished handshake with each engine, and the secret key register fed to the shuffle engine.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/rc4_sram_mux.sv | 28 ++
 rtl/rc4_phase_sequencer.sv | 121 ++++++++++++
 tb/tb_rc4_phase_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: state and phase encodings plus width defaults shared by the RC4 sequencer files.
package rc4_pkg;
    localparam int DEF_RAM_WIDTH  = 8;
    localparam int DEF_RAM_LENGTH = 8;
    localparam int DEF_KEY_WIDTH  = 24;
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_INIT_ACK = 4'd2,
        S_SHUF     = 4'd3,
        S_SHUF_ACK = 4'd4,
        S_DEC      = 4'd5,
        S_DEC_ACK  = 4'd6,
        S_CHECK    = 4'd7,
        S_DONE     = 4'd8
    } state_t;
    typedef enum logic [1:0] {
        PH_INIT = 2'd0,
        PH_SHUF = 2'd1,
        PH_DEC  = 2'd2
    } phase_t;
endpackage

// File: rtl/rc4_sram_mux.sv
// rc4_sram_mux: 3:1 S-RAM port mux selected by phase, write enable gated by i_wren_en.
module rc4_sram_mux
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
    parameter int RAM_LENGTH = DEF_RAM_LENGTH
) (
    input  logic [1:0]            i_sel,
    input  logic                  i_wren_en,
    input  logic [RAM_LENGTH-1:0] i_init_addr,
    input  logic [RAM_WIDTH-1:0]  i_init_data,
    input  logic                  i_init_wren,
    input  logic [RAM_LENGTH-1:0] i_shuf_addr,
    input  logic [RAM_WIDTH-1:0]  i_shuf_data,
    input  logic                  i_shuf_wren,
    input  logic [RAM_LENGTH-1:0] i_dec_addr,
    input  logic [RAM_WIDTH-1:0]  i_dec_data,
    input  logic                  i_dec_wren,
    output logic [RAM_LENGTH-1:0] o_addr,
    output logic [RAM_WIDTH-1:0]  o_data,
    output logic                  o_wren
);
    always_comb begin
        o_addr = i_sel == PH_SHUF ? i_shuf_addr : i_sel == PH_DEC ? i_dec_addr : i_init_addr;
        o_data = i_sel == PH_SHUF ? i_shuf_data : i_sel == PH_DEC ? i_dec_data : i_init_data;
        o_wren = i_wren_en & (i_sel == PH_SHUF ? i_shuf_wren : i_sel == PH_DEC ? i_dec_wren : i_init_wren);
    end
endmodule

// File: rtl/rc4_phase_sequencer.sv
// rc4_phase_sequencer: runs init, shuffle and decrypt engines in order on one shared S-RAM.
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
    parameter int RAM_LENGTH = DEF_RAM_LENGTH,
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [KEY_WIDTH-1:0]  i_key_in,
    input  logic                  i_msg_valid,
    output logic                  o_init_start,
    output logic                  o_shuf_start,
    output logic                  o_dec_start,
    input  logic                  i_init_finished,
    input  logic                  i_shuf_finished,
    input  logic                  i_dec_finished,
    input  logic [RAM_LENGTH-1:0] i_init_addr,
    input  logic [RAM_LENGTH-1:0] i_shuf_addr,
    input  logic [RAM_LENGTH-1:0] i_dec_addr,
    input  logic [RAM_WIDTH-1:0]  i_init_data,
    input  logic [RAM_WIDTH-1:0]  i_shuf_data,
    input  logic [RAM_WIDTH-1:0]  i_dec_data,
    input  logic                  i_init_wren,
    input  logic                  i_shuf_wren,
    input  logic                  i_dec_wren,
    output logic [RAM_LENGTH-1:0] o_s_addr,
    output logic [RAM_WIDTH-1:0]  o_s_in,
    output logic                  o_s_wren,
    output logic [KEY_WIDTH-1:0]  o_key,
    output logic                  o_done,
    output logic                  o_key_found,
    output logic                  o_key_exhausted,
    output logic [3:0]            o_state_tap
);
    state_t                 r_state, w_next;
    phase_t                 r_phase, w_phase;
    logic [KEY_WIDTH-1:0]   r_key;
    logic                   r_found, r_exhausted, w_wren_en;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_phase <= PH_INIT;
        end else begin
            r_state <= w_next;
            r_phase <= w_phase;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = i_start ? S_INIT : S_IDLE;
            S_INIT:     w_next = i_init_finished ? S_INIT_ACK : S_INIT;
            S_INIT_ACK: w_next = i_init_finished ? S_INIT_ACK : S_SHUF;
            S_SHUF:     w_next = i_shuf_finished ? S_SHUF_ACK : S_SHUF;
            S_SHUF_ACK: w_next = i_shuf_finished ? S_SHUF_ACK : S_DEC;
            S_DEC:      w_next = i_dec_finished ? S_DEC_ACK : S_DEC;
            S_DEC_ACK:  w_next = i_dec_finished ? S_DEC_ACK : S_CHECK;
`ifdef RC4_BRUTE_FORCE_EN
            S_CHECK:    w_next = (i_msg_valid || r_key == KEY_MAX) ? S_DONE : S_INIT;
`else
            S_CHECK:    w_next = S_DONE;
`endif
            S_DONE:     w_next = i_start ? S_DONE : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end
    always_comb begin
        w_phase = (r_state == S_INIT || r_state == S_INIT_ACK) ? PH_INIT :
                  (r_state == S_SHUF || r_state == S_SHUF_ACK) ? PH_SHUF :
                  (r_state == S_DEC  || r_state == S_DEC_ACK)  ? PH_DEC  : r_phase;
        w_wren_en = r_state == S_INIT || r_state == S_SHUF || r_state == S_DEC;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_key       <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
`ifdef RC4_BRUTE_FORCE_EN
            if (r_state == S_IDLE && i_start) r_key <= '0;
            if (r_state == S_CHECK && !i_msg_valid && r_key != KEY_MAX) r_key <= r_key + KEY_WIDTH'(1);
            if (r_state == S_CHECK) r_exhausted <= !i_msg_valid && r_key == KEY_MAX;
`else
            if (r_state == S_IDLE && i_start) r_key <= i_key_in;
`endif
            if (r_state == S_CHECK) r_found <= i_msg_valid;
            if (r_state == S_DONE && !i_start) begin
                r_found     <= 1'b0;
                r_exhausted <= 1'b0;
            end
        end
    end
    rc4_sram_mux #(.RAM_WIDTH(RAM_WIDTH), .RAM_LENGTH(RAM_LENGTH)) u_mux (
        .i_sel       (w_phase),
        .i_wren_en   (w_wren_en),
        .i_init_addr (i_init_addr),
        .i_init_data (i_init_data),
        .i_init_wren (i_init_wren),
        .i_shuf_addr (i_shuf_addr),
        .i_shuf_data (i_shuf_data),
        .i_shuf_wren (i_shuf_wren),
        .i_dec_addr  (i_dec_addr),
        .i_dec_data  (i_dec_data),
        .i_dec_wren  (i_dec_wren),
        .o_addr      (o_s_addr),
        .o_data      (o_s_in),
        .o_wren      (o_s_wren)
    );
    assign o_init_start    = r_state == S_INIT;
    assign o_shuf_start    = r_state == S_SHUF;
    assign o_dec_start     = r_state == S_DEC;
    assign o_done          = r_state == S_DONE;
    assign o_key           = r_key;
    assign o_key_found     = r_found;
    assign o_key_exhausted = r_exhausted;
    assign o_state_tap     = r_state;
endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// tb_rc4_phase_sequencer: randomized engine stubs, pass-level reference model and scoreboard monitor.
module tb_rc4_phase_sequencer;
    import rc4_pkg::*;
    localparam logic [23:0] KMAX  = 24'd3;
    localparam logic [24:0] NEVER = 25'h1000000;
    typedef struct {
        logic [23:0] key0;
        logic [23:0] key;
        logic        found;
        logic        exh;
        int          passes;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, msg_valid;
    logic [23:0] key_in = '0, o_key;
    logic [24:0] valid_key = NEVER;
    logic        init_start, shuf_start, dec_start, s_wren, done, found, exh;
    logic [7:0]  s_addr, s_in;
    logic [3:0]  state_tap;
    logic [2:0]  st, fin = '0, wr = '0;
    logic [7:0]  addr [3], data [3];
    int          lat [3], hold [3], cnt [3], hc [3];
    int          n_cmp = 0, n_err = 0;
    exp_t        q[$];
    always #5 clk = ~clk;
    assign st = {dec_start, shuf_start, init_start};
    assign msg_valid = ({1'b0, o_key} == valid_key);
    rc4_phase_sequencer #(.KEY_MAX(KMAX)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_key_in(key_in), .i_msg_valid(msg_valid),
        .o_init_start(init_start), .o_shuf_start(shuf_start), .o_dec_start(dec_start),
        .i_init_finished(fin[0]), .i_shuf_finished(fin[1]), .i_dec_finished(fin[2]),
        .i_init_addr(addr[0]), .i_shuf_addr(addr[1]), .i_dec_addr(addr[2]),
        .i_init_data(data[0]), .i_shuf_data(data[1]), .i_dec_data(data[2]),
        .i_init_wren(wr[0]), .i_shuf_wren(wr[1]), .i_dec_wren(wr[2]),
        .o_s_addr(s_addr), .o_s_in(s_in), .o_s_wren(s_wren), .o_key(o_key),
        .o_done(done), .o_key_found(found), .o_key_exhausted(exh), .o_state_tap(state_tap)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic exp_t model(input logic [23:0] kin, input logic [24:0] vk);
        exp_t x;
`ifdef RC4_BRUTE_FORCE_EN
        x.key0   = '0;
        x.found  = vk <= {1'b0, KMAX};
        x.exh    = !x.found;
        x.key    = x.found ? vk[23:0] : KMAX;
        x.passes = int'(x.key) + 1;
`else
        x.key0   = kin;
        x.key    = kin;
        x.found  = vk == {1'b0, kin};
        x.exh    = 1'b0;
        x.passes = 1;
`endif
        return x;
    endfunction
    always @(posedge clk) begin
        for (int e = 0; e < 3; e++) begin
            addr[e] <= 8'($urandom);
            data[e] <= 8'($urandom);
            wr[e]   <= 1'($urandom);
            if (st[e]) begin
                if (cnt[e] >= lat[e]) fin[e] <= 1'b1;
                cnt[e] <= cnt[e] + 1;
                hc[e]  <= 0;
            end else begin
                cnt[e] <= 0;
                if (fin[e] && hc[e] >= hold[e]) fin[e] <= 1'b0;
                hc[e] <= fin[e] ? hc[e] + 1 : 0;
            end
        end
    end
    int   passes = 0, nxt = 0, last = 0, age = 100;
    logic known = 1'b0, prev_done = 1'b0, prev_dfin = 1'b0, exp_wr;
    logic [2:0] prev_st = '0;
    exp_t x;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            passes = 0; nxt = 0; known = 1'b0; age = 100;
            prev_done = 1'b0; prev_dfin = 1'b0; prev_st = '0;
        end else begin
            chk("one_start", 64'($countones(st) <= 1), 1);
            exp_wr = 1'b0;
            for (int e = 0; e < 3; e++) if (st[e]) begin last = e; known = 1'b1; exp_wr = wr[e]; end
            chk("s_wren", s_wren, exp_wr);
            if (known) begin
                chk("s_addr", s_addr, addr[last]);
                chk("s_in", s_in, data[last]);
            end
            for (int e = 0; e < 3; e++) if (st[e] && !prev_st[e]) begin
                chk("start_order", e, nxt);
                nxt = (e + 1) % 3;
                if (e == 1) chk("shuf_after_init_fin_low", fin[0], 0);
                if (e == 0) begin
                    if (q.size() > 0) chk("pass_key", o_key, q[0].key0 + 24'(passes));
                    passes++;
                end
            end
            age = (prev_dfin && !fin[2]) ? 0 : age + 1;
            if (done && !prev_done) begin
                chk("done_latency", age, 2);
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    x = q.pop_front();
                    chk("final_key", o_key, x.key);
                    chk("key_found", found, x.found);
                    chk("key_exhausted", exh, x.exh);
                    chk("pass_count", passes, x.passes);
                end
                passes = 0;
            end
            prev_done = done; prev_dfin = fin[2]; prev_st = st;
        end
    end
    task automatic rand_timing();
        for (int e = 0; e < 3; e++) begin
            lat[e]  = $urandom_range(0, 12);
            hold[e] = $urandom_range(0, 4);
        end
    endtask
    task automatic finish_pass();
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk("done_timeout", done, 1);
        repeat (20) begin
            @(negedge clk);
            chk("done_hold", done, 1);
            chk("no_restart", st, 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("found_clear", found, 0);
        chk("exh_clear", exh, 0);
    endtask
    task automatic run_pass(input logic [23:0] kin, input logic [24:0] vk);
        q.push_back(model(kin, vk));
        key_in = kin; valid_key = vk; start = 1'b1;
        finish_pass();
    endtask
    initial begin
        logic [23:0] k;
        int n;
        lat = '{5, 10, 8}; hold = '{0, 0, 0};
        repeat (3) @(negedge clk);
        chk("rst_starts", st, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_exh", exh, 0);
        chk("rst_key", o_key, 0);
        chk("rst_wren", s_wren, 0);
        chk("rst_state", state_tap, S_IDLE);
        rst = 1'b0;
        @(negedge clk);
        run_pass(24'h000249, 25'h0000249);
        rand_timing(); hold[0] = 4;
        k = 24'($urandom);
        run_pass(k, {1'b0, k ^ 24'h1});
`ifdef RC4_BRUTE_FORCE_EN
        rand_timing();
        run_pass(24'($urandom), 25'd2);
        rand_timing();
        run_pass(24'($urandom), NEVER);
`else
        for (int i = 0; i < 6; i++) begin
            rand_timing();
            k = 24'($urandom);
            run_pass(k, $urandom_range(0, 1) == 1 ? {1'b0, k} : NEVER);
        end
`endif
        rand_timing();
        k = 24'($urandom);
        key_in = k; valid_key = {1'b0, k}; start = 1'b1;
        n = 0;
        while (!shuf_start && n < 500) begin @(negedge clk); n++; end
        chk("shuf_reached", shuf_start, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_starts", st, 0);
        chk("mid_rst_state", state_tap, S_IDLE);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_key", o_key, 0);
        #1;
        q.push_back(model(k, {1'b0, k}));
        rst = 1'b0;
        finish_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
